// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the MAC processing element.
// Helpers work on a 64-bit carrier, so accumulator widths up to 63 bits are supported.
package mac_pkg;

   localparam int MAX_W = 64;

   typedef logic [MAX_W-1:0] wide_t;

   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } tag_t;

   function automatic wide_t ext_val(input wide_t v, input int w, input logic sgn);
      wide_t mask;
      mask = ~wide_t'(0) >> (MAX_W - w);
      if (sgn && v[w-1]) return v | ~mask;
      return v & mask;
   endfunction

   function automatic wide_t max_val(input int w, input logic sgn);
      return sgn ? (~wide_t'(0) >> (MAX_W - w + 1)) : (~wide_t'(0) >> (MAX_W - w));
   endfunction

   function automatic wide_t min_val(input int w, input logic sgn);
      return sgn ? (~wide_t'(0) << (w - 1)) : '0;
   endfunction

   // Both operands are w-bit values; the 64-bit sum cannot overflow for w <= 63,
   // so the clamp compares against the true mathematical result.
   function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w,
                                     input logic sgn, input logic sat);
      wide_t sum;
      wide_t hi;
      wide_t lo;
      sum = ext_val(a, w, sgn) + ext_val(b, w, sgn);
      hi  = max_val(w, sgn);
      lo  = min_val(w, sgn);
      if (sat) begin
         if (sgn) begin
            if ($signed(sum) > $signed(hi)) sum = hi;
            else if ($signed(sum) < $signed(lo)) sum = lo;
         end else if (sum > hi) begin
            sum = hi;
         end
      end
      return sum;
   endfunction

endpackage

// File: rtl/mac_mul_pipe.sv
// Lane multipliers, lane sum and a tagged MUL_STAGES-deep pipeline.
module mac_mul_pipe
   import mac_pkg::*;
#(
   parameter int A_WIDTH    = 8,
   parameter int B_WIDTH    = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int LANES      = 1,
   parameter int MUL_STAGES = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       sgn,
   input  tag_t                       in_tag,
   input  logic [LANES*A_WIDTH-1:0]   a_i,
   input  logic [LANES*B_WIDTH-1:0]   b_i,
   output logic [ACC_WIDTH-1:0]       out_sum,
   output tag_t                       out_tag,
   output logic                       any_valid
);

   logic [ACC_WIDTH-1:0] lane_sum;
   logic [ACC_WIDTH-1:0] sum_q [MUL_STAGES];
   logic [ACC_WIDTH-1:0] sum_d [MUL_STAGES];
   tag_t                 tag_q [MUL_STAGES];
   tag_t                 tag_d [MUL_STAGES];

   // Operands are extended to the accumulator width first, so the low bits of the
   // product are exact in both signed and unsigned modes.
   always_comb begin
      logic [ACC_WIDTH-1:0] a_ext;
      logic [ACC_WIDTH-1:0] b_ext;
      lane_sum = '0;
      a_ext    = '0;
      b_ext    = '0;
      for (int l = 0; l < LANES; l++) begin
         a_ext    = ACC_WIDTH'(ext_val(wide_t'(a_i[l*A_WIDTH +: A_WIDTH]), A_WIDTH, sgn));
         b_ext    = ACC_WIDTH'(ext_val(wide_t'(b_i[l*B_WIDTH +: B_WIDTH]), B_WIDTH, sgn));
         lane_sum = lane_sum + a_ext * b_ext;
      end
   end

   always_comb begin
      sum_d = sum_q;
      tag_d = tag_q;
      if (en) begin
         sum_d[0] = lane_sum;
         tag_d[0] = in_tag;
         for (int s = 1; s < MUL_STAGES; s++) begin
            sum_d[s] = sum_q[s-1];
            tag_d[s] = tag_q[s-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < MUL_STAGES; s++) begin
            sum_q[s] <= '0;
            tag_q[s] <= '0;
         end
      end else begin
         sum_q <= sum_d;
         tag_q <= tag_d;
      end
   end

   always_comb begin
      any_valid = 1'b0;
      for (int s = 0; s < MUL_STAGES; s++) any_valid = any_valid | tag_q[s].valid;
   end

   assign out_sum = sum_q[MUL_STAGES-1];
   assign out_tag = tag_q[MUL_STAGES-1];

endmodule

// File: rtl/mac_pe.sv
// Systolic-array processing element: term countdown, accumulator, operand
// forwarding and the daisy-chained result path.
module mac_pe
   import mac_pkg::*;
#(
   parameter int A_WIDTH    = 8,
   parameter int B_WIDTH    = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int CNT_WIDTH  = 8,
   parameter int LANES      = 1,
   parameter int MUL_STAGES = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       cfg_signed,
   input  logic                       cfg_sat,
   input  logic                       num_valid,
   input  logic [CNT_WIDTH-1:0]       num,
   output logic                       num_valid_r,
   output logic [CNT_WIDTH-1:0]       num_r,
   input  logic [LANES*A_WIDTH-1:0]   a_i,
   input  logic [LANES*B_WIDTH-1:0]   b_i,
   output logic [LANES*A_WIDTH-1:0]   a_r,
   output logic [LANES*B_WIDTH-1:0]   b_r,
   input  logic                       result_in_valid,
   input  logic [ACC_WIDTH-1:0]       result_in,
   output logic                       result_out_valid,
   output logic [ACC_WIDTH-1:0]       result_out,
   output logic                       busy,
   output logic                       collide
);

   logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
   logic [ACC_WIDTH-1:0]     acc_q, acc_d;
   logic [ACC_WIDTH-1:0]     result_q, result_d;
   logic                     result_valid_q, result_valid_d;
   logic                     collide_q, collide_d;
   logic                     nv_r_q, nv_r_d;
   logic [CNT_WIDTH-1:0]     num_r_q, num_r_d;
   logic [LANES*A_WIDTH-1:0] a_r_q, a_r_d;
   logic [LANES*B_WIDTH-1:0] b_r_q, b_r_d;

   tag_t                     in_tag;
   tag_t                     pipe_tag;
   logic [ACC_WIDTH-1:0]     pipe_sum;
   logic                     pipe_busy;

   // A fresh num_valid restarts the countdown; terms already in flight carry their own tags.
   always_comb begin
      in_tag.valid = num_valid || (cnt_q != '0);
      in_tag.first = num_valid;
      in_tag.last  = (num_valid && (num == '0)) || (!num_valid && (cnt_q == CNT_WIDTH'(1)));
   end

   mac_mul_pipe #(
      .A_WIDTH   (A_WIDTH),
      .B_WIDTH   (B_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .LANES     (LANES),
      .MUL_STAGES(MUL_STAGES)
   ) u_mul_pipe (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .sgn      (cfg_signed),
      .in_tag   (in_tag),
      .a_i      (a_i),
      .b_i      (b_i),
      .out_sum  (pipe_sum),
      .out_tag  (pipe_tag),
      .any_valid(pipe_busy)
   );

   always_comb begin
      cnt_d          = cnt_q;
      acc_d          = acc_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      collide_d      = collide_q;
      nv_r_d         = nv_r_q;
      num_r_d        = num_r_q;
      a_r_d          = a_r_q;
      b_r_d          = b_r_q;
      if (en) begin
         if (num_valid) cnt_d = num;
         else if (cnt_q != '0) cnt_d = cnt_q - CNT_WIDTH'(1);
         nv_r_d         = num_valid;
         num_r_d        = num;
         a_r_d          = a_i;
         b_r_d          = b_i;
         result_d       = result_in;
         result_valid_d = result_in_valid;
         if (pipe_tag.valid) begin
            acc_d = ACC_WIDTH'(sat_add(pipe_tag.first ? '0 : wide_t'(acc_q), wide_t'(pipe_sum),
                                       ACC_WIDTH, cfg_signed, cfg_sat));
            // A local completion takes the chain slot; any upstream result is dropped.
            if (pipe_tag.last) begin
               result_d       = acc_d;
               result_valid_d = 1'b1;
               collide_d      = collide_q | result_in_valid;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q          <= '0;
         acc_q          <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         collide_q      <= 1'b0;
         nv_r_q         <= 1'b0;
         num_r_q        <= '0;
         a_r_q          <= '0;
         b_r_q          <= '0;
      end else begin
         cnt_q          <= cnt_d;
         acc_q          <= acc_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         collide_q      <= collide_d;
         nv_r_q         <= nv_r_d;
         num_r_q        <= num_r_d;
         a_r_q          <= a_r_d;
         b_r_q          <= b_r_d;
      end
   end

   assign num_valid_r      = nv_r_q;
   assign num_r            = num_r_q;
   assign a_r              = a_r_q;
   assign b_r              = b_r_q;
   assign result_out       = result_q;
   assign result_out_valid = result_valid_q;
   assign collide          = collide_q;
   assign busy             = (cnt_q != '0) || pipe_busy;

endmodule

// File: tb/tb_mac_pe.sv
// Directed bench for mac_pe (16-bit accumulator, one lane, one multiplier stage)
// with a scoreboard of expected chain results keyed by enabled-cycle count.
module tb_mac_pe;

   localparam int AW = 16;
   localparam int CW = 8;
   localparam int MS = 1;

   typedef struct {
      logic [AW-1:0] val;
      int            due;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          cfg_signed;
   logic          cfg_sat;
   logic          num_valid;
   logic [CW-1:0] num;
   logic          num_valid_r;
   logic [CW-1:0] num_r;
   logic [7:0]    a_i;
   logic [7:0]    b_i;
   logic [7:0]    a_r;
   logic [7:0]    b_r;
   logic          result_in_valid;
   logic [AW-1:0] result_in;
   logic          result_out_valid;
   logic [AW-1:0] result_out;
   logic          busy;
   logic          collide;

   int   tests_run    = 0;
   int   tests_failed = 0;
   int   ecyc         = 0;
   exp_t sb[$];
   logic [7:0] pa [8];
   logic [7:0] pb [8];

   mac_pe #(
      .A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(AW), .CNT_WIDTH(CW), .LANES(1), .MUL_STAGES(MS)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .cfg_signed(cfg_signed), .cfg_sat(cfg_sat),
      .num_valid(num_valid), .num(num), .num_valid_r(num_valid_r), .num_r(num_r),
      .a_i(a_i), .b_i(b_i), .a_r(a_r), .b_r(b_r),
      .result_in_valid(result_in_valid), .result_in(result_in),
      .result_out_valid(result_out_valid), .result_out(result_out),
      .busy(busy), .collide(collide)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      if (sb.size() > 0 && sb[0].due == ecyc) begin
         check("result_valid", 64'(result_out_valid), 64'(1));
         check("result_value", 64'(result_out), 64'(sb[0].val));
         void'(sb.pop_front());
      end else begin
         check("no_result", 64'(result_out_valid), 64'(0));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (en) begin
         ecyc++;
         checkOutput();
      end
   endtask

   task automatic idle(input int n);
      num_valid       = 1'b0;
      a_i             = '0;
      b_i             = '0;
      result_in_valid = 1'b0;
      result_in       = '0;
      repeat (n) tick();
   endtask

   // Independent reference: integer dot product, clamped or wrapped per step.
   function automatic logic [AW-1:0] model(input int n, input logic sgn, input logic sat);
      longint acc;
      longint p;
      longint ai;
      longint bi;
      acc = 0;
      for (int i = 0; i < n; i++) begin
         ai  = sgn ? longint'($signed(pa[i])) : longint'(pa[i]);
         bi  = sgn ? longint'($signed(pb[i])) : longint'(pb[i]);
         p   = ai * bi;
         acc = (i == 0) ? p : acc + p;
         if (sat) begin
            if (sgn) begin
               if (acc > 32767) acc = 32767;
               if (acc < -32768) acc = -32768;
            end else if (acc > 65535) begin
               acc = 65535;
            end
         end else begin
            acc = acc & 64'hFFFF;
         end
      end
      return acc[AW-1:0];
   endfunction

   // Drives one n-term product from pa/pb; optionally stalls after term stall_at.
   task automatic applyStimulus(input int n, input int stall_at, input int stall_len);
      logic [AW-1:0] expv;
      expv = model(n, cfg_signed, cfg_sat);
      for (int i = 0; i < n; i++) begin
         num_valid = (i == 0);
         num       = CW'(n - 1);
         a_i       = pa[i];
         b_i       = pb[i];
         tick();
         if (i == 0) begin
            check("num_valid_r_start", 64'(num_valid_r), 64'(1));
            check("num_r_start", 64'(num_r), 64'(n - 1));
            check("a_r_start", 64'(a_r), 64'(pa[0]));
         end
         if (i == 1) check("num_valid_r_second", 64'(num_valid_r), 64'(0));
         if (i == n - 1) sb.push_back('{expv, ecyc + MS});
         if (i == stall_at) begin
            en        = 1'b0;
            num_valid = 1'b1;
            a_i       = 8'hAA;
            b_i       = 8'h55;
            repeat (stall_len) begin
               tick();
               check("stall_a_r", 64'(a_r), 64'(pa[i]));
               check("stall_b_r", 64'(b_r), 64'(pb[i]));
               check("stall_num_r", 64'(num_r), 64'(n - 1));
               check("stall_result_valid", 64'(result_out_valid), 64'(0));
               check("stall_busy", 64'(busy), 64'(1));
            end
            en = 1'b1;
         end
      end
      num_valid = 1'b0;
      a_i       = '0;
      b_i       = '0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; cfg_signed = 1'b0; cfg_sat = 1'b0;
      num_valid = 1'b0; num = '0; a_i = '0; b_i = '0;
      result_in_valid = 1'b0; result_in = '0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_result_valid", 64'(result_out_valid), 64'(0));
      check("reset_result", 64'(result_out), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_collide", 64'(collide), 64'(0));
      check("reset_num_valid_r", 64'(num_valid_r), 64'(0));

      // Unsigned dot product, then the same product back-to-back.
      pa = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0};
      pb = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
      applyStimulus(4, -1, 0);
      applyStimulus(4, -1, 0);
      check("busy_running", 64'(busy), 64'(1));
      idle(4);
      check("busy_idle", 64'(busy), 64'(0));

      // Signed versus unsigned on the same operands.
      pa = '{8'h80, 8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      pb = '{8'h80, 8'h02, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      cfg_signed = 1'b1;
      applyStimulus(2, -1, 0);
      idle(3);
      cfg_signed = 1'b0;
      applyStimulus(2, -1, 0);
      idle(3);

      // Saturating versus wrapping signed accumulation.
      pa = '{8'd127, 8'd127, 8'd127, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      pb = '{8'd127, 8'd127, 8'd127, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      cfg_signed = 1'b1;
      cfg_sat    = 1'b1;
      applyStimulus(3, -1, 0);
      idle(3);
      cfg_sat = 1'b0;
      applyStimulus(3, -1, 0);
      idle(3);
      cfg_signed = 1'b0;

      // Stall for three cycles after the second pair.
      pa = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0};
      pb = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
      applyStimulus(4, 1, 3);
      idle(3);

      // Upstream result colliding with a local completion, then a lone pass-through.
      pa = '{8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      pb = '{8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      applyStimulus(1, -1, 0);
      check("collide_before", 64'(collide), 64'(0));
      result_in_valid = 1'b1;
      result_in       = 16'hDEAD;
      tick();
      check("collide_set", 64'(collide), 64'(1));
      result_in = 16'hBEEF;
      sb.push_back('{16'hBEEF, ecyc + 1});
      tick();
      idle(2);
      check("collide_sticky", 64'(collide), 64'(1));

      // Restart mid-count: only the new single-term product completes.
      num_valid = 1'b1; num = 8'd5; a_i = 8'd1; b_i = 8'd1;
      tick();
      num_valid = 1'b0;
      tick();
      tick();
      num_valid = 1'b1; num = 8'd0; a_i = 8'd2; b_i = 8'd3;
      tick();
      sb.push_back('{16'd6, ecyc + MS});
      idle(8);
      check("restart_busy", 64'(busy), 64'(0));

      // Reset in the middle of a product.
      num_valid = 1'b1; num = 8'd3; a_i = 8'd5; b_i = 8'd5;
      tick();
      num_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_result", 64'(result_out), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_collide", 64'(collide), 64'(0));
      check("rst_a_r", 64'(a_r), 64'(0));
      check("rst_num_r", 64'(num_r), 64'(0));
      idle(6);

      check("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
